// File: rtl/nvdla_glb_intr_ctrl.sv
// Global interrupt controller: sticky per-group done status with mask, SW set and W1C,
// optional count/timeout coalescing, and a CSB register port with a fixed 1-cycle response.
module nvdla_glb_intr_ctrl #(
  parameter int unsigned NUM_SRC    = 6,
  parameter logic [31:0] HW_VERSION = 32'h0001_0000,
  parameter int unsigned TMO_W      = 16,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic [2*NUM_SRC-1:0]   src_done_intr_pd,
  input  logic                   csb2glb_req_pvld,
  output logic                   csb2glb_req_prdy,
  input  logic [62:0]            csb2glb_req_pd,
  output logic                   glb2csb_resp_valid,
  output logic [33:0]            glb2csb_resp_pd,
  output logic                   core_intr
);

  localparam int unsigned W = 2 * NUM_SRC;

  localparam logic [11:0] ADDR_VERSION = 12'h000;
  localparam logic [11:0] ADDR_MASK    = 12'h001;
  localparam logic [11:0] ADDR_SET     = 12'h002;
  localparam logic [11:0] ADDR_STATUS  = 12'h003;
  localparam logic [11:0] ADDR_CFG     = 12'h004;
  localparam logic [11:0] ADDR_TIMEOUT = 12'h005;

  // request fields
  logic              rdy_q;
  logic              accept;
  logic              wr_acc;
  logic [11:0]       req_addr;
  logic [31:0]       req_wdat;
  logic              req_write;
  logic              req_nposted;
  logic              unused_req_bits;

  // register file
  logic [W-1:0]      status_q;
  logic [W-1:0]      mask_q;
  logic              coal_en_q;
  logic [CNT_W-1:0]  thr_q;
  logic [TMO_W-1:0]  timeout_q;

  // write strobes and read mux
  logic              mask_we;
  logic              set_we;
  logic              status_we;
  logic              cfg_we;
  logic              tmo_we;
  logic [W-1:0]      sw_set;
  logic [W-1:0]      w1c_clear;
  logic [31:0]       rd_data;
  logic              addr_err;

  // interrupt logic
  logic [W-1:0]      pending;
  logic [CNT_W-1:0]  pcount;
  logic [CNT_W-1:0]  thr_eff;
  logic              thr_hit;
  logic              tmo_hit;
  logic [TMO_W-1:0]  timer_q;
  logic              intr_q;

  // response
  logic              resp_valid_q;
  logic [33:0]       resp_pd_q;

  assign req_addr    = csb2glb_req_pd[11:0];
  assign req_wdat    = csb2glb_req_pd[53:22];
  assign req_write   = csb2glb_req_pd[54];
  assign req_nposted = csb2glb_req_pd[55];

  // upper address bits and reserved fields are don't-care for this block
  assign unused_req_bits = ^{csb2glb_req_pd[62:56], csb2glb_req_pd[21:12], req_wdat};

  // ready is withheld during reset; a pending response is dropped by reset
  assign csb2glb_req_prdy   = rdy_q & ~nvdla_core_rst;
  assign glb2csb_resp_valid = resp_valid_q & ~nvdla_core_rst;
  assign glb2csb_resp_pd    = resp_pd_q;
  assign core_intr          = intr_q;

  assign accept = csb2glb_req_pvld & csb2glb_req_prdy;
  assign wr_acc = accept & req_write;

  assign mask_we   = wr_acc & (req_addr == ADDR_MASK);
  assign set_we    = wr_acc & (req_addr == ADDR_SET);
  assign status_we = wr_acc & (req_addr == ADDR_STATUS);
  assign cfg_we    = wr_acc & (req_addr == ADDR_CFG);
  assign tmo_we    = wr_acc & (req_addr == ADDR_TIMEOUT);

  assign sw_set    = set_we    ? req_wdat[W-1:0] : '0;
  assign w1c_clear = status_we ? req_wdat[W-1:0] : '0;

  // read data / address error decode
  always_comb begin
    rd_data  = '0;
    addr_err = 1'b0;
    case (req_addr)
      ADDR_VERSION: rd_data = HW_VERSION;
      ADDR_MASK:    rd_data = 32'(mask_q);
      ADDR_SET:     rd_data = '0;
      ADDR_STATUS:  rd_data = 32'(status_q);
      ADDR_CFG: begin
        rd_data[CNT_W-1:0] = thr_q;
        rd_data[31]        = coal_en_q;
      end
      ADDR_TIMEOUT: rd_data = 32'(timeout_q);
      default:      addr_err = 1'b1;
    endcase
  end

  // CSB handshake and response register
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      rdy_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_pd_q    <= '0;
    end else begin
      rdy_q        <= 1'b1;
      resp_valid_q <= accept & (~req_write | req_nposted);
      if (accept) begin
        resp_pd_q <= req_write ? {1'b1, addr_err, 32'h0000_0000}
                               : {1'b0, addr_err, rd_data};
      end
    end
  end

  // control registers
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      mask_q    <= '1;
      coal_en_q <= 1'b0;
      thr_q     <= CNT_W'(1);
      timeout_q <= '0;
    end else begin
      if (mask_we) mask_q <= req_wdat[W-1:0];
      if (cfg_we) begin
        thr_q     <= req_wdat[CNT_W-1:0];
        coal_en_q <= req_wdat[31];
      end
      if (tmo_we) timeout_q <= req_wdat[TMO_W-1:0];
    end
  end

  // sticky status: set (HW or SW) beats a same-cycle W1C
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~w1c_clear) | src_done_intr_pd | sw_set;
    end
  end

  assign pending = status_q & ~mask_q;

  always_comb begin
    pcount = '0;
    for (int i = 0; i < int'(W); i++) begin
      pcount = pcount + CNT_W'(pending[i]);
    end
  end

  assign thr_eff = (thr_q == '0) ? CNT_W'(1) : thr_q;
  assign thr_hit = (pcount >= thr_eff);
  assign tmo_hit = (timeout_q != '0) && (timer_q == (timeout_q - TMO_W'(1)));

  // interrupt output and coalescing timer
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      intr_q  <= 1'b0;
      timer_q <= '0;
    end else if (!coal_en_q) begin
      intr_q  <= |pending;
      timer_q <= '0;
    end else if (pending == '0) begin
      intr_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      if (timer_q != '1) timer_q <= timer_q + TMO_W'(1);
      if (thr_hit || tmo_hit) intr_q <= 1'b1;
    end
  end

endmodule
